// File: rtl/wb_shared_bus_arb.sv
// Wishbone shared-bus arbiter: NUM_MASTERS masters share one bus to NUM_SLAVES slaves, round-robin.
// Latency: grant registered 1 cycle after cyc on an idle bus; request and response paths are combinational.
// Backpressure: non-preemptive; waiting masters hold cyc until granted, a stalled slave holds the bus.
//
// Ports: clk_i/rst_i (async active-high reset); m_* flattened master side (master k at [k*W +: W]),
// m_data_o read data broadcast to all masters; s_* shared slave side with per-slave cyc/stb;
// gnt_o one-hot owner (0 when idle), busy_o bus owned.
// Optional: define WB_SBUS_TIMEOUT_EN to add a watchdog that errors a transfer stalled TIMEOUT_CYCLES cycles.
module wb_shared_bus_arb #(
  parameter int NUM_MASTERS    = 4,
  parameter int NUM_SLAVES     = 8,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int SB             = $clog2(NUM_SLAVES),
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS*AW-1:0]   m_addr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_data_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  output logic [DW-1:0]               m_data_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic [NUM_MASTERS-1:0]      m_rty_o,
  output logic [NUM_SLAVES-1:0]       s_cyc_o,
  output logic [NUM_SLAVES-1:0]       s_stb_o,
  output logic                        s_we_o,
  output logic [AW-1:0]               s_addr_o,
  output logic [DW-1:0]               s_data_o,
  output logic [DW/8-1:0]             s_sel_o,
  input  logic [NUM_SLAVES*DW-1:0]    s_data_i,
  input  logic [NUM_SLAVES-1:0]       s_ack_i,
  input  logic [NUM_SLAVES-1:0]       s_err_i,
  input  logic [NUM_SLAVES-1:0]       s_rty_i,
  output logic [NUM_MASTERS-1:0]      gnt_o,
  output logic                        busy_o
);

  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = DW / 8;
  // Slave count widened by one bit so the decode-miss compare never wraps.
  localparam logic [SB:0] NSLV = (SB + 1)'(NUM_SLAVES);

  typedef enum logic [1:0] {IDLE, OWNED, DECERR} state_t;

  state_t                 state;
  logic [MW-1:0]          last_q;
  logic [NUM_MASTERS-1:0] dec_err_q;

  // Granted master's request, selected by the one-hot grant.
  logic          own_cyc, own_stb, own_we;
  logic [AW-1:0] own_addr;
  logic [DW-1:0] own_data;
  logic [SW-1:0] own_sel;
  logic [MW-1:0] own_idx;

  always_comb begin
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    own_we   = 1'b0;
    own_addr = '0;
    own_data = '0;
    own_sel  = '0;
    own_idx  = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (gnt_o[k]) begin
        own_cyc  = m_cyc_i[k];
        own_stb  = m_stb_i[k];
        own_we   = m_we_i[k];
        own_addr = m_addr_i[k*AW +: AW];
        own_data = m_data_i[k*DW +: DW];
        own_sel  = m_sel_i[k*SW +: SW];
        own_idx  = MW'(k);
      end
    end
  end

  logic [SB-1:0]         dsel;
  logic                  dec_miss;
  logic [NUM_SLAVES-1:0] dec_oh;

  assign dsel     = own_addr[AW-1 -: SB];
  assign dec_miss = {1'b0, dsel} >= NSLV;
  assign dec_oh   = NUM_SLAVES'(1) << dsel;

  // Only the decoded slave's response is looked at; other slaves are ignored.
  logic          rsp_ack, rsp_err, rsp_rty;
  logic [DW-1:0] rsp_data;

  always_comb begin
    rsp_ack  = 1'b0;
    rsp_err  = 1'b0;
    rsp_rty  = 1'b0;
    rsp_data = '0;
    for (int j = 0; j < NUM_SLAVES; j++) begin
      if (dsel == SB'(j)) begin
        rsp_ack  = s_ack_i[j];
        rsp_err  = s_err_i[j];
        rsp_rty  = s_rty_i[j];
        rsp_data = s_data_i[j*DW +: DW];
      end
    end
  end

  logic to_fire;

`ifdef WB_SBUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          stalled;

  assign stalled = busy_o && (state == OWNED) && !dec_miss && own_cyc && own_stb
                   && !(rsp_ack || rsp_err || rsp_rty);
  // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle, counting the current one.
  assign to_fire = stalled && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                    to_cnt <= '0;
    else if (stalled && !to_fire) to_cnt <= to_cnt + 1'b1;
    else                          to_cnt <= '0;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign to_fire        = 1'b0;
`endif

  logic slv_en, rsp_vld;
  assign slv_en  = busy_o && !dec_miss && !to_fire;
  assign rsp_vld = busy_o && !dec_miss;

  assign s_cyc_o  = {NUM_SLAVES{slv_en & own_cyc}} & dec_oh;
  assign s_stb_o  = {NUM_SLAVES{slv_en & own_cyc & own_stb}} & dec_oh;
  assign s_we_o   = own_we;
  assign s_addr_o = own_addr;
  assign s_data_o = own_data;
  assign s_sel_o  = own_sel;

  assign m_data_o = rsp_vld ? rsp_data : '0;
  assign m_ack_o  = gnt_o & {NUM_MASTERS{rsp_vld & rsp_ack}};
  assign m_rty_o  = gnt_o & {NUM_MASTERS{rsp_vld & rsp_rty}};
  assign m_err_o  = (gnt_o & {NUM_MASTERS{(rsp_vld & rsp_err) | to_fire}}) | dec_err_q;

  // Round-robin pick: first requester searching upward from last_q+1 with wrap.
  logic [NUM_MASTERS-1:0] rr_pick;
  logic [MW-1:0]          rr_idx;
  logic                   rr_found;

  always_comb begin
    rr_pick  = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      rr_idx = MW'((int'(last_q) + i) % NUM_MASTERS);
      if (!rr_found && m_cyc_i[rr_idx]) begin
        rr_pick[rr_idx] = 1'b1;
        rr_found        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      gnt_o     <= '0;
      busy_o    <= 1'b0;
      last_q    <= MW'(NUM_MASTERS - 1);
      dec_err_q <= '0;
    end else begin
      dec_err_q <= '0;
      case (state)
        IDLE: begin
          if (|m_cyc_i) begin
            gnt_o  <= rr_pick;
            busy_o <= 1'b1;
            state  <= OWNED;
          end
        end
        OWNED: begin
          if (!own_cyc) begin
            last_q <= own_idx;
            gnt_o  <= '0;
            busy_o <= 1'b0;
            state  <= IDLE;
          end else if (dec_miss && own_stb) begin
            // Error goes out next cycle; OWNED must see stb again before another one.
            dec_err_q <= gnt_o;
            state     <= DECERR;
          end
        end
        DECERR:  state <= OWNED;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_shared_bus_arb.md
Name: wb_shared_bus_arb

Overview:
- Parametrised Wishbone shared-bus interconnect for SoC integration: NUM_MASTERS classic Wishbone masters share one bus to NUM_SLAVES slaves.
- Round-robin arbitration; slave select decoded from the top address bits.
- Decode misses get an internal error response.
- Successor to the fixed 8x16 interconnect: configurable counts and widths, grant status, and an optional bus-timeout watchdog.

Parameters:
- NUM_MASTERS, 4, number of masters (2..8).
- NUM_SLAVES, 8, number of slaves (2..16).
- AW, 32, address width.
- DW, 32, data width; SEL width = DW/8.
- SB, $clog2(NUM_SLAVES), slave-select bits taken from addr[AW-1 -: SB].
- TIMEOUT_CYCLES, 255, watchdog limit; used only with WB_SBUS_TIMEOUT_EN.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- m_cyc_i  in  NUM_MASTERS  per-master CYC
- m_stb_i  in  NUM_MASTERS  per-master STB
- m_we_i  in  NUM_MASTERS  per-master WE
- m_addr_i  in  NUM_MASTERS*AW  flattened master addresses, master k at [k*AW +: AW]
- m_data_i  in  NUM_MASTERS*DW  flattened master write data
- m_sel_i  in  NUM_MASTERS*DW/8  flattened byte selects
- m_data_o  out  DW  read data, broadcast to all masters
- m_ack_o  out  NUM_MASTERS  per-master ACK
- m_err_o  out  NUM_MASTERS  per-master ERR
- m_rty_o  out  NUM_MASTERS  per-master RTY
- s_cyc_o  out  NUM_SLAVES  per-slave CYC
- s_stb_o  out  NUM_SLAVES  per-slave STB
- s_we_o  out  1  shared WE
- s_addr_o  out  AW  shared address
- s_data_o  out  DW  shared write data
- s_sel_o  out  DW/8  shared byte select
- s_data_i  in  NUM_SLAVES*DW  flattened slave read data
- s_ack_i  in  NUM_SLAVES  per-slave ACK
- s_err_i  in  NUM_SLAVES  per-slave ERR
- s_rty_i  in  NUM_SLAVES  per-slave RTY
- gnt_o  out  NUM_MASTERS  one-hot current grant, 0 when idle
- busy_o  out  1  bus owned

Behaviour:

Reset
- Reset is asynchronous and active-high on rst_i; clock is clk_i.
- All outputs 0 during reset.
- FSM goes to IDLE; last-grant pointer resets to NUM_MASTERS-1, so master 0 has first priority.

FSM states
- IDLE:
  - Outputs zero.
  - If any m_cyc_i is high, register a grant to the first requesting master searching upward (with wrap) from last+1.
  - Go to OWNED next cycle.
- OWNED:
  - gnt_o and busy_o high.
  - Granted master's we/addr/data/sel drive the s_* buses combinationally.
  - s_cyc_o[d] and s_stb_o[d] follow that master's cyc/stb, where d = addr[AW-1 -: SB].
  - All other s_cyc_o/s_stb_o bits are 0.
  - Slave d's ack/err/rty/data route to the granted master only; ack/err/rty of non-granted masters are 0.
  - When the granted master drops cyc, update the pointer and return to IDLE.
  - Minimum one IDLE cycle between owners.
- DECERR (decode miss, only when d >= NUM_SLAVES):
  - No slave strobed.
  - m_err_o asserted to the owner for exactly one cycle, registered one cycle after stb is seen.
  - Stb must be seen again before a further err.
  - Then return to OWNED.

Arbitration and timing
- Arbitration is non-preemptive.
- Simultaneous requests resolve by round-robin order only.
- A request arriving the same cycle as a release is considered in the next IDLE evaluation.
- Grant latency from cyc rise on an idle bus: 1 cycle to gnt_o; slave strobed in the same cycle as gnt_o.
- Ack latency is the slave's own; no added registering on the response path.
- If multiple s_ack_i/s_err_i/s_rty_i bits are high, only slave d is observed.

Reset mid-operation
- Drop all strobes immediately (asynchronous).
- No response is issued to the interrupted master.

Optional Feature:

Macro: WB_SBUS_TIMEOUT_EN

With the macro defined:
- A counter of width $clog2(TIMEOUT_CYCLES+1) increments each OWNED cycle where the owner's stb is high and no ack/err/rty has returned.
- When the count equals TIMEOUT_CYCLES:
  - s_stb_o and s_cyc_o to the slave are forced low for that cycle.
  - m_err_o is pulsed to the owner for one cycle.
  - The counter clears.
- The counter also clears on any response or on stb low.

Without the macro:
- No counter and no timeout.
- A hung slave holds the bus indefinitely.

Test Plan:
1. Reset, then m_cyc_i=4'b0001 and m_stb_i=4'b0001 with addr 32'h2000_0010 (d=1), we=1, data 32'hDEAD_BEEF; slave 1 acks 2 cycles later -> gnt_o=0001 one cycle after cyc; s_stb_o=8'h02; s_addr_o=32'h2000_0010; s_data_o=32'hDEADBEEF; m_ack_o=0001 in the same cycle as s_ack_i[1].
2. All four masters hold cyc continuously, each releasing after one acked transfer -> grant order 0,1,2,3,0, with one IDLE cycle between grants.
3. Master 2 reads addr 32'hE000_0000 (d=7); slave 7 returns data 32'h1234_5678 with ack -> m_data_o=32'h12345678; m_ack_o=0100; m_ack_o bits 0, 1, 3 stay 0.
4. Config NUM_SLAVES=6, master 0 accesses addr 32'hE000_0000 (d=7) -> no s_stb_o bit set; m_err_o[0] pulses for 1 cycle, one cycle after stb.
5. With WB_SBUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave 3 never responds -> m_err_o[0] pulses on the 8th stalled cycle; s_stb_o[3] low that cycle. Without the macro, the bus remains owned for 100 cycles.
6. Assert rst_i mid-transfer while slave 4 is strobed -> s_stb_o, gnt_o and busy_o go to 0 immediately. After release, master 0 is granted first when masters 0 and 3 request together.
